// File: rtl/lg_pkg.sv
// Shared types, gate bit positions and golden truth function for the logicgates self-test.
package lg_pkg;

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} lg_state_e;

  localparam int unsigned IDX_AND  = 0;
  localparam int unsigned IDX_OR   = 1;
  localparam int unsigned IDX_NOT  = 2;
  localparam int unsigned IDX_XOR  = 3;
  localparam int unsigned IDX_XNOR = 4;
  localparam int unsigned IDX_NAND = 5;
  localparam int unsigned IDX_NOR  = 6;

  localparam int unsigned NUM_VECTORS = 4;

  function automatic logic [6:0] lg_golden(input logic i1, input logic i2);
    logic [6:0] g;
    g           = '0;
    g[IDX_AND]  = i1 & i2;
    g[IDX_OR]   = i1 | i2;
    g[IDX_NOT]  = ~i1;
    g[IDX_XOR]  = i1 ^ i2;
    g[IDX_XNOR] = ~(i1 ^ i2);
    g[IDX_NAND] = ~(i1 & i2);
    g[IDX_NOR]  = ~(i1 | i2);
    return g;
  endfunction

endpackage

// File: rtl/lg_settle_cnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module lg_settle_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic [Width-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/logicgates_bist.sv
// Self-test driver/checker for the two-input logicgates block.
// Optional first-failure capture ports are enabled by defining LGBIST_FAILCAP_EN.
module logicgates_bist
  import lg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       i1,
  output logic       i2,
  input  logic [6:0] o_vec,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [6:0] gate_fail
`ifdef LGBIST_FAILCAP_EN
  ,
  output logic       first_fail_valid,
  output logic [1:0] first_fail_idx,
  output logic [6:0] first_fail_obs
`endif
);

  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LastIdx    = 2'(NUM_VECTORS - 1);

  lg_state_e  state_q, state_d;
  logic [1:0] vec_idx_q;
  logic [7:0] cnt;
  logic       cnt_zero;
  logic       accept, cnt_load, cnt_dec, do_check, last_vec;
  logic [6:0] mismatch;
  logic [2:0] err_next;

  lg_settle_cnt #(
    .Width(8)
  ) u_settle_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(SettleLoad),
    .dec     (cnt_dec),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StSettle;
      StSettle:       if (cnt_zero) state_d = StCheck;
      StCheck:        state_d = last_vec ? StDone : StSettle;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    accept   = start && ((state_q == StIdle) || (state_q == StDone));
    do_check = (state_q == StCheck);
    last_vec = (vec_idx_q == LastIdx);
    cnt_dec  = (state_q == StSettle);
    cnt_load = accept || (do_check && !last_vec);
  end

  // Golden comes from the registered drive, so it matches what the gates actually see.
  assign mismatch = o_vec ^ lg_golden(i1, i2);
  assign err_next = err_count + {2'b00, |mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1        <= 1'b0;
      i2        <= 1'b0;
      vec_idx_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      gate_fail <= '0;
    end else if (accept) begin
      i1        <= 1'b0;
      i2        <= 1'b0;
      vec_idx_q <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      gate_fail <= '0;
    end else if (do_check) begin
      gate_fail <= gate_fail | mismatch;
      err_count <= err_next;
      if (last_vec) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_next == '0);
      end else begin
        vec_idx_q  <= vec_idx_q + 2'd1;
        {i1, i2}   <= vec_idx_q + 2'd1;
      end
    end
  end

`ifdef LGBIST_FAILCAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_obs   <= '0;
    end else if (accept) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_obs   <= '0;
    end else if (do_check && (mismatch != '0) && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_idx   <= vec_idx_q;
      first_fail_obs   <= o_vec;
    end
  end
`endif

endmodule

// File: tb/tb_logicgates_bist.sv
// Directed bench for logicgates_bist: gate model with injectable faults, three settle settings.
module tb_logicgates_bist;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fault_mode = 0;  // 0 none, 1 AND stuck 0, 2 NOT stuck 1

  // Main instance, SETTLE_CYCLES=2
  logic       start, i1, i2, busy, done, pass;
  logic [2:0] err_count;
  logic [6:0] gate_fail, o_vec;
  // SETTLE_CYCLES=1 and 255 instances
  logic       s1_start, s1_i1, s1_i2, s1_busy, s1_done, s1_pass;
  logic [2:0] s1_err;
  logic [6:0] s1_gf, s1_ovec;
  logic       s9_start, s9_i1, s9_i2, s9_busy, s9_done, s9_pass;
  logic [2:0] s9_err;
  logic [6:0] s9_gf, s9_ovec;
`ifdef LGBIST_FAILCAP_EN
  logic       ff_valid, s1_ffv, s9_ffv;
  logic [1:0] ff_idx, s1_ffi, s9_ffi;
  logic [6:0] ff_obs, s1_ffo, s9_ffo;
`endif

  // Behavioural logicgates block, {NOR,NAND,XNOR,XOR,NOT,OR,AND}
  function automatic logic [6:0] gates(input logic a, input logic b);
    return {~(a | b), ~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
  endfunction

  always_comb begin
    o_vec = gates(i1, i2);
    if (fault_mode == 1) o_vec[0] = 1'b0;
    if (fault_mode == 2) o_vec[2] = 1'b1;
  end
  assign s1_ovec = gates(s1_i1, s1_i2);
  assign s9_ovec = gates(s9_i1, s9_i2);

  logicgates_bist #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i1(i1), .i2(i2), .o_vec(o_vec),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .gate_fail(gate_fail)
`ifdef LGBIST_FAILCAP_EN
    , .first_fail_valid(ff_valid), .first_fail_idx(ff_idx), .first_fail_obs(ff_obs)
`endif
  );

  logicgates_bist #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .i1(s1_i1), .i2(s1_i2), .o_vec(s1_ovec),
    .busy(s1_busy), .done(s1_done), .pass(s1_pass), .err_count(s1_err), .gate_fail(s1_gf)
`ifdef LGBIST_FAILCAP_EN
    , .first_fail_valid(s1_ffv), .first_fail_idx(s1_ffi), .first_fail_obs(s1_ffo)
`endif
  );

  logicgates_bist #(.SETTLE_CYCLES(255)) u_dut_s255 (
    .clk(clk), .rst_n(rst_n), .start(s9_start), .i1(s9_i1), .i2(s9_i2), .o_vec(s9_ovec),
    .busy(s9_busy), .done(s9_done), .pass(s9_pass), .err_count(s9_err), .gate_fail(s9_gf)
`ifdef LGBIST_FAILCAP_EN
    , .first_fail_valid(s9_ffv), .first_fail_idx(s9_ffi), .first_fail_obs(s9_ffo)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run on the main instance; glitch_k >= 1 pulses start at that cycle.
  task automatic run_main(input int fault, input logic [2:0] exp_err, input logic [6:0] exp_gf,
                          input logic exp_pass, input int glitch_k);
    int k;
    fault_mode = fault;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_done", done, 0);
    check_eq("accept_pass", pass, 0);
    check_eq("accept_err", err_count, 0);
    check_eq("accept_gf", gate_fail, 0);
    check_eq("vec_0", {i1, i2}, 0);
    k = 0;
    while (!done && k < 40) begin
      k++;
      if (k == glitch_k) start = 1'b1;
      tick();
      start = 1'b0;
      if (!done && (k % 3 == 0)) check_eq($sformatf("vec_at_%0d", k), {i1, i2}, k / 3);
    end
    check_eq("done_cycle", k, 12);
    check_eq("done_busy", busy, 0);
    check_eq("done_pass", pass, exp_pass);
    check_eq("done_err", err_count, exp_err);
    check_eq("done_gf", gate_fail, exp_gf);
  endtask

  initial begin
    int c1, c9;
    rst_n = 1'b0;
    start = 1'b0;
    s1_start = 1'b0;
    s9_start = 1'b0;
    tick();
    tick();
    check_eq("rst_i", {i1, i2}, 0);
    check_eq("rst_flags", {busy, done, pass}, 0);
    check_eq("rst_err", err_count, 0);
    check_eq("rst_gf", gate_fail, 0);
    rst_n = 1'b1;
    tick();

    // Clean run, then hold: done must persist without start.
    run_main(0, 3'd0, 7'h00, 1'b1, 0);
    tick();
    tick();
    check_eq("done_held", {done, pass}, 2'b11);

    // Restart from DONE with AND stuck 0; a start pulse mid-run must not disturb timing.
    run_main(1, 3'd1, 7'b0000001, 1'b0, 4);
`ifdef LGBIST_FAILCAP_EN
    check_eq("ff_valid", ff_valid, 1);
    check_eq("ff_idx", ff_idx, 3);
    check_eq("ff_obs", ff_obs, 7'b0010010);
`endif

    // NOT stuck 1: vectors 10 and 11 mismatch.
    run_main(2, 3'd2, 7'b0000100, 1'b0, 0);
`ifdef LGBIST_FAILCAP_EN
    check_eq("ff_idx_not", ff_idx, 2);
    check_eq("ff_obs_not", ff_obs, 7'b0101110);
`endif

    // Reset during SETTLE of vector 2 with a failing run in flight.
    fault_mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check_eq("pre_rst_vec", {i1, i2}, 2);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_i", {i1, i2}, 0);
    check_eq("midrst_flags", {busy, done}, 0);
    check_eq("midrst_err", err_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("midrst_idle", {busy, done}, 0);
    run_main(0, 3'd0, 7'h00, 1'b1, 0);

    // Settle extremes.
    s1_start = 1'b1;
    s9_start = 1'b1;
    tick();
    s1_start = 1'b0;
    s9_start = 1'b0;
    c1 = -1;
    c9 = -1;
    for (int k = 1; k <= 1100 && c9 < 0; k++) begin
      tick();
      if (s1_done && c1 < 0) c1 = k;
      if (s9_done && c9 < 0) c9 = k;
    end
    check_eq("s1_cycles", c1, 8);
    check_eq("s255_cycles", c9, 1024);
    check_eq("s1_pass", {s1_pass, s1_err, s1_gf}, {1'b1, 3'd0, 7'd0});
    check_eq("s255_pass", {s9_pass, s9_err, s9_gf}, {1'b1, 3'd0, 7'd0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
